// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: turns debounced key events into a validated 1-2 digit decimal value,
// held with a valid/ack handshake toward the charger controller.
module keypad_entry_ctrl #(
    parameter int unsigned MAX_VALUE      = 60,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       press,
    input  logic       value_ack,
    output logic [6:0] entry_value,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic [1:0] digit_count,
    output logic       value_valid,
    output logic       key_error
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StEntry = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 2);
    localparam logic [6:0]      MaxVal  = 7'(MAX_VALUE);

    localparam logic [3:0] KeyConfirm = 4'd10;
    localparam logic [3:0] KeyClear   = 4'd11;
    localparam logic [3:0] KeyBack    = 4'd12;

    logic [1:0]      state_q, state_d;
    logic [3:0]      hi_q, hi_d;
    logic [3:0]      lo_q, lo_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            press_q;
    logic            err_q, err_d;
    logic [CntW-1:0] tmo_q, tmo_d;

    logic       key_event;
    logic       is_digit;
    logic [6:0] value;

    assign key_event = press & ~press_q;
    assign is_digit  = (key_value <= 4'd9);
    // hi*10 built from shifts so the 7-bit sum never truncates (max 99).
    assign value     = {hi_q, 3'b000} + {2'b00, hi_q, 1'b0} + {3'b000, lo_q};

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        tmo_d   = '0;
        case (state_q)
            StEmpty: begin
                if (key_event) begin
                    if (is_digit && (key_value != 4'd0)) begin
                        lo_d    = key_value;
                        cnt_d   = 2'd1;
                        state_d = StEntry;
                    end else if (key_value == KeyConfirm) begin
                        err_d = 1'b1;
                    end
                end
            end
            StEntry: begin
                tmo_d = tmo_q + 1'b1;
                if (key_event) begin
                    tmo_d = '0;
                    if (is_digit) begin
                        if (cnt_q == 2'd1) begin
                            hi_d  = lo_q;
                            lo_d  = key_value;
                            cnt_d = 2'd2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_value == KeyConfirm) begin
                        if (value <= MaxVal) begin
                            state_d = StHold;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_value == KeyClear) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        cnt_d   = '0;
                        state_d = StEmpty;
                    end else if (key_value == KeyBack) begin
                        if (cnt_q == 2'd2) begin
                            lo_d  = hi_q;
                            hi_d  = '0;
                            cnt_d = 2'd1;
                        end else begin
                            lo_d    = '0;
                            cnt_d   = '0;
                            state_d = StEmpty;
                        end
                    end
                end else if (tmo_q == TmoLast) begin
                    // Counter is about to reach TIMEOUT_CYCLES-1: discard like a clear.
                    tmo_d   = '0;
                    hi_d    = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    state_d = StEmpty;
                end
            end
            StHold: begin
                if (value_ack) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    state_d = StEmpty;
                end
            end
            default: begin
                hi_d    = '0;
                lo_d    = '0;
                cnt_d   = '0;
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            press_q <= press;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign entry_value = value;
    assign digit_hi    = hi_q;
    assign digit_lo    = lo_q;
    assign digit_count = cnt_q;
    assign value_valid = (state_q == StHold);
    assign key_error   = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; a second instance with a short timeout covers expiry.
module tb_keypad_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_value;
    logic       press;
    logic       value_ack;

    logic [6:0] entry_value, t_entry_value;
    logic [3:0] digit_hi, t_digit_hi;
    logic [3:0] digit_lo, t_digit_lo;
    logic [1:0] digit_count, t_digit_count;
    logic       value_valid, t_value_valid;
    logic       key_error, t_key_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    keypad_entry_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_value  (key_value),
        .press      (press),
        .value_ack  (value_ack),
        .entry_value(entry_value),
        .digit_hi   (digit_hi),
        .digit_lo   (digit_lo),
        .digit_count(digit_count),
        .value_valid(value_valid),
        .key_error  (key_error)
    );

    keypad_entry_ctrl #(
        .MAX_VALUE     (60),
        .TIMEOUT_CYCLES(50)
    ) dut_to (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_value  (key_value),
        .press      (press),
        .value_ack  (value_ack),
        .entry_value(t_entry_value),
        .digit_hi   (t_digit_hi),
        .digit_lo   (t_digit_lo),
        .digit_count(t_digit_count),
        .value_valid(t_value_valid),
        .key_error  (t_key_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a key for 'hold' cycles, then release for one cycle.
    task automatic press_key(input logic [3:0] k, input int hold);
        key_value = k;
        press     = 1'b1;
        tick(hold);
        press = 1'b0;
        tick(1);
    endtask

    task automatic ack_pulse();
        value_ack = 1'b1;
        tick(1);
        value_ack = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [6:0] v, input logic [1:0] c,
                               input logic vv);
        check_eq({tag, ".value"}, entry_value, v);
        check_eq({tag, ".count"}, digit_count, c);
        check_eq({tag, ".valid"}, value_valid, vv);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_value = '0;
        press     = 1'b0;
        value_ack = 1'b0;
        tick(3);
        check_state("reset", 7'd0, 2'd0, 1'b0);
        check_eq("reset.hi", digit_hi, 0);
        check_eq("reset.lo", digit_lo, 0);
        check_eq("reset.err", key_error, 0);
        rst_n = 1'b1;
        tick(1);

        // Long holds produce one event each.
        key_value = 4'd4;
        press     = 1'b1;
        tick(300);
        check_eq("hold4.count", digit_count, 1);
        check_eq("hold4.lo", digit_lo, 4);
        press = 1'b0;
        tick(1);
        key_value = 4'd2;
        press     = 1'b1;
        tick(4000);
        check_eq("hold2.hi", digit_hi, 4);
        check_eq("hold2.lo", digit_lo, 2);
        check_state("hold2", 7'd42, 2'd2, 1'b0);
        press = 1'b0;
        tick(1);

        // Confirm 42, keys ignored in HOLD, ack clears.
        press_key(4'd10, 1);
        check_state("conf42", 7'd42, 2'd2, 1'b1);
        press_key(4'd7, 1);
        press_key(4'd11, 1);
        check_state("hold_keys", 7'd42, 2'd2, 1'b1);
        check_eq("hold_keys.err", key_error, 0);
        ack_pulse();
        check_state("ack", 7'd0, 2'd0, 1'b0);

        // Leading zeros dropped.
        press_key(4'd0, 1);
        press_key(4'd0, 1);
        check_eq("zeros.count", digit_count, 0);
        press_key(4'd5, 1);
        press_key(4'd10, 1);
        check_state("conf5", 7'd5, 2'd1, 1'b1);
        ack_pulse();

        // 75 exceeds MAX_VALUE.
        press_key(4'd7, 1);
        press_key(4'd5, 1);
        key_value = 4'd10;
        press     = 1'b1;
        tick(1);
        check_eq("conf75.err", key_error, 1);
        check_state("conf75", 7'd75, 2'd2, 1'b0);
        press = 1'b0;
        tick(1);
        check_eq("conf75.err_pulse", key_error, 0);
        press_key(4'd11, 1);
        check_state("clear", 7'd0, 2'd0, 1'b0);

        // Boundary: exactly MAX_VALUE is accepted.
        press_key(4'd6, 1);
        press_key(4'd0, 1);
        press_key(4'd10, 1);
        check_state("conf60", 7'd60, 2'd2, 1'b1);
        ack_pulse();

        // 99 is representable.
        press_key(4'd9, 1);
        press_key(4'd9, 1);
        check_state("v99", 7'd99, 2'd2, 1'b0);
        press_key(4'd11, 1);

        // Third digit rejected, backspace twice, confirm in EMPTY.
        press_key(4'd3, 1);
        press_key(4'd8, 1);
        key_value = 4'd9;
        press     = 1'b1;
        tick(1);
        check_eq("third.err", key_error, 1);
        press = 1'b0;
        tick(1);
        check_state("third", 7'd38, 2'd2, 1'b0);
        press_key(4'd12, 1);
        check_eq("bs1.lo", digit_lo, 3);
        check_eq("bs1.hi", digit_hi, 0);
        check_eq("bs1.count", digit_count, 1);
        press_key(4'd12, 1);
        check_state("bs2", 7'd0, 2'd0, 1'b0);
        key_value = 4'd10;
        press     = 1'b1;
        tick(1);
        check_eq("empty_conf.err", key_error, 1);
        press = 1'b0;
        tick(1);
        key_value = 4'd13;
        press     = 1'b1;
        tick(1);
        check_eq("code13.err", key_error, 0);
        check_eq("code13.count", digit_count, 0);
        press = 1'b0;
        tick(1);

        // Ack and key in the same HOLD cycle: ack wins.
        press_key(4'd2, 1);
        press_key(4'd10, 1);
        check_eq("pre_race.valid", value_valid, 1);
        value_ack = 1'b1;
        key_value = 4'd5;
        press     = 1'b1;
        tick(1);
        value_ack = 1'b0;
        check_state("race", 7'd0, 2'd0, 1'b0);
        tick(1);
        check_state("race_drop", 7'd0, 2'd0, 1'b0);
        press = 1'b0;
        tick(1);

        // Async reset in HOLD.
        press_key(4'd4, 1);
        press_key(4'd2, 1);
        press_key(4'd10, 1);
        check_state("pre_rst", 7'd42, 2'd2, 1'b1);
        rst_n = 1'b0;
        #2;
        check_state("async_rst", 7'd0, 2'd0, 1'b0);
        check_eq("async_rst.hi", digit_hi, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        press_key(4'd7, 1);
        check_eq("post_rst.count", digit_count, 1);
        check_eq("post_rst.lo", digit_lo, 7);

        // Timeout on the short-timeout instance.
        do_reset();
        press_key(4'd6, 1);
        tick(47);
        check_eq("tmo48.count", t_digit_count, 1);
        tick(1);
        check_eq("tmo49.count", t_digit_count, 0);
        check_eq("tmo49.lo", t_digit_lo, 0);
        check_eq("tmo49.err", t_key_error, 0);
        press_key(4'd6, 1);
        tick(47);
        key_value = 4'd1;
        press     = 1'b1;
        tick(1);
        check_eq("tmo_key.value", t_entry_value, 61);
        check_eq("tmo_key.count", t_digit_count, 2);
        press = 1'b0;
        tick(45);
        check_eq("tmo_restart.count", t_digit_count, 2);
        tick(4);
        check_eq("tmo_restart_exp.count", t_digit_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Consumer end of the keyboard scanner's key_value/press interface. It turns debounced key events into a validated 1-2 digit decimal entry (charging minutes), with backspace, clear and confirm. The confirmed value goes to the charger controller through a valid/ack handshake, and the digits go to the display driver.

Parameters:
MAX_VALUE, 60, largest value accepted on confirm (1..99).
TIMEOUT_CYCLES, 10000, idle clock cycles in ENTRY before the entry is discarded (10 s at 1 kHz).

Ports:
clk  input  1  system clock, 1 kHz.
rst_n  input  1  asynchronous active-low reset.
key_value  input  4  key code from the scanner; valid while press=1.
press  input  1  high while a debounced key is held.
value_ack  input  1  downstream has taken entry_value.
entry_value  output  7  10*digit_hi + digit_lo, combinational from the digit registers.
digit_hi  output  4  BCD tens digit.
digit_lo  output  4  BCD ones digit.
digit_count  output  2  number of digits entered (0..2).
value_valid  output  1  high in HOLD; entry_value is stable while it is high.
key_error  output  1  one-cycle pulse when a key is rejected.

Behaviour:
- Reset (asynchronous): state EMPTY; all outputs 0; press_d=0; timeout counter 0.
- Key decode: 0-9 digit; 10 confirm; 11 clear; 12 backspace; 13-15 ignored, with no error.
- Event detection: event = press & ~press_d, where press_d is press registered.
  - A held key produces exactly one event.
  - key_value is sampled in the event cycle.
  - Outputs update at the same rising edge that samples the event.
- States: EMPTY (count 0), ENTRY (count 1-2), HOLD (value_valid=1).
- EMPTY:
  - digit 1-9: lo=d, count=1, go to ENTRY.
  - digit 0: ignored; leading zeros are not stored.
  - confirm: key_error pulse.
  - clear, backspace: ignored.
- ENTRY, digit:
  - count=1: hi=lo, lo=d, count=2.
  - count=2: ignored, key_error pulse.
- ENTRY, backspace:
  - count=2: lo=hi, hi=0, count=1.
  - count=1: lo=0, count=0, go to EMPTY.
- ENTRY, clear: hi=lo=0, count=0, go to EMPTY.
- ENTRY, confirm:
  - entry_value <= MAX_VALUE: go to HOLD; value_valid=1 from that edge.
  - otherwise: key_error pulse, stay in ENTRY with digits unchanged.
- HOLD:
  - value_valid, digits and count stay frozen.
  - All key events are ignored, with no error.
  - value_ack=1 sampled: next edge clears value_valid, digits and count, and goes to EMPTY.
- value_ack outside HOLD: ignored.
- A key event and value_ack in the same HOLD cycle: ack wins and the key is dropped.
- Timeout:
  - The counter runs only in ENTRY.
  - Every event, whether accepted or rejected, zeroes it.
  - Reaching TIMEOUT_CYCLES-1 gives the same result as clear; no key_error.
  - In EMPTY and HOLD the counter is held at 0.
- key_error: registered, high for exactly one cycle after the rejecting event.
- Widths: entry_value is 7 bits and the maximum is 99. Compute it as hi*8 + hi*2 + lo, with no truncation.
- Reset mid-operation: immediate return to the reset values, including mid-HOLD; any pending value is lost.

Test Plan:
- Key 4 held 300 cycles, then released; then key 2 held 4000 cycles -> one event per press; digits hi=4, lo=2, count=2, entry_value=42; no repeats during the long hold.
- 4, 2, confirm -> value_valid=1, entry_value=42; keys 7 and clear during HOLD change nothing. value_ack pulse -> next cycle value_valid=0, count=0, entry_value=0.
- 0, 0, 5, confirm -> leading zeros dropped; entry_value=5, HOLD. Then 7, 5, confirm -> key_error pulse (75 > 60), stays in ENTRY with 75.
- 3, 8, 9 -> third digit rejected with key_error; backspace -> count=1, lo=3, hi=0; backspace -> EMPTY; confirm in EMPTY -> key_error.
- With TIMEOUT_CYCLES=50: key 6, then idle 49 cycles -> cleared to EMPTY, no key_error. Idle 48 cycles, then key 1 -> entry 61 kept, counter restarts.
- rst_n low while in HOLD with 42 -> all outputs 0 without waiting for a clock edge; after release, the block accepts a new entry from EMPTY.
